cpu_lsu: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 38 +++
 rtl/cpu_lsu_if.sv | 23 ++
 rtl/cpu_lsu_align.sv | 52 +++++
 rtl/cpu_lsu.sv | 135 +++++++++++++
 tb/tb_cpu_lsu.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU memory path: decoded commands, access sizes and the
// load/store unit state, plus the alignment legality rule used by the LSU.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    OTHER   = 2'b00,
    JMP_CMD = 2'b01,
    ST_CMD  = 2'b10,
    LW_CMD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    SZ_FULL  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_BYTE  = 2'b10,
    SZ_UPPER = 2'b11
  } size_e;

  localparam logic SIGN   = 1'b1;
  localparam logic UNSIGN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  // Full words must be word aligned, halves half aligned; the upper size code is never legal.
  function automatic logic access_legal(size_e size, logic [1:0] addr_lo);
    case (size)
      SZ_FULL: return addr_lo == 2'b00;
      SZ_HALF: return !addr_lo[0];
      SZ_BYTE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_lsu_if.sv
// Single-outstanding req/ack data-memory bus between the LSU (master) and memory (slave).
interface cpu_lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cpu_lsu_align.sv
// Byte-lane logic of the LSU: strobe generation, store data replication and
// load lane selection with sign/zero extension. Purely combinational.
module cpu_lsu_align
  import cpu_mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        ext;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch behind.
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rword;
    ext       = (sign == SIGN);
    half_lane = addr_lo[1] ? rword[31:16] : rword[15:0];
    byte_lane = rword[7:0];

    case (addr_lo)
      2'b01:   byte_lane = rword[15:8];
      2'b10:   byte_lane = rword[23:16];
      2'b11:   byte_lane = rword[31:24];
      default: byte_lane = rword[7:0];
    endcase

    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{ext & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{ext & half_lane[15]}}, half_lane};
      end
      SZ_FULL: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: captures a decoded memory command, runs one req/ack bus access and
// returns extended load data. Define LSU_TIMEOUT_EN to add a WAIT-state watchdog.
module cpu_lsu
  import cpu_mem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd,
  input  logic [2:0]    sx_cntl,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          lsu_err,
  cpu_lsu_if.master     mem
);

  lsu_state_e    state, state_nxt;
  logic          mem_op, legal, timeout;
  logic          we_q, sign_q, err_q;
  size_e         size_q;
  logic [1:0]    addr_lo_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  size_e         al_size;
  logic [1:0]    al_lo;
  logic [3:0]    al_be;
  logic [DW-1:0] al_wdata, al_rdata;

  assign mem_op = (state == IDLE) && (cmd == LW_CMD || cmd == ST_CMD);
  assign legal  = access_legal(size_e'(sx_cntl[1:0]), addr[1:0]);

  // While idle the lanes follow the incoming command; afterwards they follow the captured access.
  assign al_size = (state == IDLE) ? size_e'(sx_cntl[1:0]) : size_q;
  assign al_lo   = (state == IDLE) ? addr[1:0] : addr_lo_q;

  cpu_lsu_align u_align (
    .size      (al_size),
    .addr_lo   (al_lo),
    .sign      (sign_q),
    .wdata     (wdata),
    .rword     (mem.mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 255) ? 16 : 8;
  logic [TW-1:0] wd_cnt;

  // Counter is held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst_n)                       wd_cnt <= '0;
    else if (state != WAIT)           wd_cnt <= '0;
    else if (!mem.mem_ack)            wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) && !mem.mem_ack && (wd_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rdata_vld = 1'b0;
    lsu_err   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          state_nxt = legal ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.mem_ack || timeout) state_nxt = DONE;
      end
      DONE: begin
        rdata_vld = !we_q && !err_q;
        lsu_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state and capture registers use non-blocking assignment so every register sees pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_FULL;
      addr_lo_q <= 2'b00;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (mem_op) begin
        we_q      <= (cmd == ST_CMD);
        sign_q    <= sx_cntl[2];
        size_q    <= size_e'(sx_cntl[1:0]);
        addr_lo_q <= addr[1:0];
        err_q     <= !legal;
        addr_q    <= {addr[AW-1:2], 2'b00};
        be_q      <= al_be;
        wdata_q   <= al_wdata;
        if (!legal) rdata <= '0;
      end
      if (state == WAIT && mem.mem_ack && !we_q) rdata <= al_rdata;
      if (timeout) begin
        err_q <= 1'b1;
        rdata <= '0;
      end
    end
  end

  assign mem.mem_req   = (state == WAIT);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Scoreboard bench for cpu_lsu: directed and random accesses against a behavioural model.
module tb_cpu_lsu;
  import cpu_mem_pkg::*;

  localparam int TCYC = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [2:0]  sx_cntl = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, rdata_vld, lsu_err;
  logic [31:0] rdata;

  cpu_lsu_if #(.AW(32), .DW(32)) bus ();

  cpu_lsu #(.AW(32), .DW(32), .TIMEOUT_CYC(TCYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .sx_cntl   (sx_cntl),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .lsu_err   (lsu_err),
    .mem       (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        vld;
    logic        err;
    logic [31:0] rdata;
  } res_t;

  typedef struct {
    int          delay;
    logic [31:0] rword;
    bit          late_ack;
  } plan_t;

  bus_t  bus_q[$];
  res_t  res_q[$];
  plan_t plan_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: nothing expected, saw 0x%08h", name, act);
  endtask

  // Reference model: derives bus beat, result and stall length from the access rules.
  function automatic void model(input logic [1:0] c, input logic [2:0] sx, input logic [31:0] a,
                                input logic [31:0] w, input logic [31:0] rw, input int dly,
                                output bit is_mem, output bit ok, output bus_t b, output res_t r,
                                output int ncyc);
    int          lo, bits;
    bit          tmo;
    logic [31:0] lane;
    lo     = int'(a[1:0]);
    is_mem = (c == LW_CMD) || (c == ST_CMD);
    case (sx[1:0])
      2'b00:   ok = (lo % 4 == 0);
      2'b01:   ok = (lo % 2 == 0);
      2'b10:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    tmo    = TO_EN && ok && (dly >= TCYC);
    b.we   = (c == ST_CMD);
    b.addr = a & ~32'h3;
    case (sx[1:0])
      2'b10: begin
        bits = 8;  b.be = 4'(1 << lo);           b.wdata = {24'h0, w[7:0]} * 32'h0101_0101;
      end
      2'b01: begin
        bits = 16; b.be = (lo >= 2) ? 4'hC : 4'h3; b.wdata = {16'h0, w[15:0]} * 32'h0001_0001;
      end
      default: begin
        bits = 32; b.be = 4'hF;                   b.wdata = w;
      end
    endcase
    if (bits == 32) lane = rw;
    else begin
      lane = (rw >> (8 * lo)) & ((32'd1 << bits) - 32'd1);
      if (sx[2] != UNSIGN && lane >= (32'd1 << (bits - 1))) lane = lane - (32'd1 << bits);
    end
    r.vld   = is_mem && ok && !tmo && (c == LW_CMD);
    r.err   = is_mem && (!ok || tmo);
    r.rdata = r.err ? 32'h0 : lane;
    if (!is_mem)  ncyc = 0;
    else if (!ok) ncyc = 1;
    else if (tmo) ncyc = 1 + TCYC;
    else          ncyc = dly + 2;
  endfunction

  task automatic issue(input logic [1:0] c, input logic [2:0] sx, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rw, input int dly);
    bit    is_mem, ok;
    bus_t  b;
    res_t  r;
    plan_t p;
    int    ncyc, n;
    model(c, sx, a, w, rw, dly, is_mem, ok, b, r, ncyc);
    if (is_mem && ok) begin
      bus_q.push_back(b);
      p.delay = dly; p.rword = rw; p.late_ack = 1'b0;
      plan_q.push_back(p);
    end
    if (r.vld || r.err) res_q.push_back(r);
    @(posedge clk); #1;
    cmd = c; sx_cntl = sx; addr = a; wdata = w;
    n = 0;
    @(negedge clk);
    while (stall && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", n, ncyc);
    check("retire_vld", rdata_vld, r.vld);
    check("retire_err", lsu_err, r.err);
  endtask

  // Memory responder: acks each request after the planned number of WAIT cycles.
  initial begin : responder
    plan_t p;
    bit    dropped;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else begin
          p.delay = 0; p.rword = 32'hDEAD_BEEF; p.late_ack = 1'b0;
        end
        dropped = 1'b0;
        for (int k = 0; k < p.delay; k++) begin
          @(negedge clk);
          if (!bus.mem_req) begin
            dropped = 1'b1;
            break;
          end
        end
        if (dropped && p.late_ack) repeat (2) @(negedge clk);
        if (!dropped || p.late_ack) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = p.rword;
          @(posedge clk); #1;
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom();
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a bus request or a result pulse.
  initial begin : monitor
    bit   prev_req;
    bus_t e, hold;
    res_t r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_req = 1'b0;
      else begin
        if (bus.mem_req && !prev_req) begin
          if (bus_q.size() == 0) flag("unexpected_req", bus.mem_addr);
          else begin
            e = bus_q.pop_front();
            check("req_we", bus.mem_we, e.we);
            check("req_addr", bus.mem_addr, e.addr);
            check("req_be", bus.mem_be, e.be);
            if (e.we) check("req_wdata", bus.mem_wdata, e.wdata);
          end
          hold.we = bus.mem_we; hold.addr = bus.mem_addr;
          hold.be = bus.mem_be; hold.wdata = bus.mem_wdata;
        end else if (bus.mem_req) begin
          check("hold_we", bus.mem_we, hold.we);
          check("hold_addr", bus.mem_addr, hold.addr);
          check("hold_be", bus.mem_be, hold.be);
          check("hold_wdata", bus.mem_wdata, hold.wdata);
        end
        prev_req = bus.mem_req;
        if (rdata_vld || lsu_err) begin
          if (res_q.size() == 0) flag("unexpected_result", {30'h0, rdata_vld, lsu_err});
          else begin
            r = res_q.pop_front();
            check("res_vld", rdata_vld, r.vld);
            check("res_err", lsu_err, r.err);
            check("res_rdata", rdata, r.rdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit          is_mem, ok;
    bus_t        b;
    res_t        r;
    plan_t       p;
    int          ncyc;
    logic [31:0] a, rw;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_rdata", rdata, 0);
    check("rst_vld", rdata_vld, 0);
    check("rst_err", lsu_err, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_be", bus.mem_be, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(LW_CMD, 3'b110, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    issue(LW_CMD, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
    issue(LW_CMD, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
    issue(ST_CMD, 3'b110, 32'h0000_3001, 32'h1234_56AB, 32'h0, 0);
    issue(LW_CMD, 3'b000, 32'h0000_4002, 32'h0, 32'h0, 0);
    issue(LW_CMD, 3'b000, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 5);
    issue(ST_CMD, 3'b011, 32'h0000_5004, 32'h5555_AAAA, 32'h0, 0);
    issue(JMP_CMD, 3'b000, 32'h0000_5008, 32'h0, 32'h0, 0);
    issue(LW_CMD, 3'b010, 32'h0000_5001, 32'h0, 32'h0000_00FF, 1);
`ifdef LSU_TIMEOUT_EN
    issue(LW_CMD, 3'b000, 32'h0000_7000, 32'h0, 32'h1111_2222, 20);
`endif

    // Reset while the bus is stalled; the late ack afterwards must be ignored.
    rw = 32'h7777_8888;
    model(LW_CMD, 3'b000, 32'h0000_6000, 32'h0, rw, 100, is_mem, ok, b, r, ncyc);
    bus_q.push_back(b);
    p.delay = 100; p.rword = rw; p.late_ack = 1'b1;
    plan_q.push_back(p);
    @(posedge clk); #1;
    cmd = LW_CMD; sx_cntl = 3'b000; addr = 32'h0000_6000;
    @(negedge clk);
    check("mid_rst_stall0", stall, 1);
    repeat (3) @(negedge clk);
    check("mid_rst_req_before", bus.mem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cmd   = OTHER;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_req_drop", bus.mem_req, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_ack_req", bus.mem_req, 0);
      check("late_ack_stall", stall, 0);
    end
    check("late_ack_rdata", rdata, 0);

    for (int i = 0; i < 200; i++) begin
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, $urandom(), $urandom(),
            $urandom_range(0, 6));
    end

    @(posedge clk); #1;
    cmd = OTHER;
    repeat (8) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    check("plan_q_drained", plan_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
